// File: rtl/riscv_pkg.sv
// Shared core package: datapath widths, load-size encoding and the
// writeback FSM state type used by writeback_unit and load_extend.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int WB_CNT_W   = 16;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_WORD3 = 2'd3
  } load_size_t;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment: picks the byte/halfword lane from the
// address LSBs and sign- or zero-extends it to XLEN.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  load_size_t      size,
  input  logic            is_unsigned,
  input  logic [1:0]      lsb,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    result    = rdata;

    case (lsb)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase

    half_lane = lsb[1] ? rdata[31:16] : rdata[15:0];

    // Size 3 is not a legal RISC-V load width; it falls through to word.
    case (size)
      LS_BYTE: result = {{(XLEN-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      LS_HALF: result = {{(XLEN-16){~is_unsigned & half_lane[15]}}, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results directly, waits for load data with a
// bounded timeout, and drives the register-file write port.
// Optional macro WB_FORWARD_EN enables the same-cycle bypass copy on fwd_*.
//
// Handshake: an instruction transfers on a rising edge where ex_valid_i and
// ex_ready_o are both high; ex_ready_o is high exactly in WB_IDLE and upstream
// holds every ex_* input stable until it sees the transfer.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0]       ex_result_i,
  input  logic                  ex_is_load_i,
  input  logic [1:0]            ex_load_size_i,
  input  logic                  ex_load_unsigned_i,
  input  logic [1:0]            ex_addr_lsb_i,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  rf_write_en_o,
  output logic [REG_ADDR_W-1:0] rf_write_addr_o,
  output logic [XLEN-1:0]       rf_write_data_o,
  output logic                  pend_valid_o,
  output logic [REG_ADDR_W-1:0] pend_rd_o,
  output logic                  load_err_o,
  output logic                  fwd_valid_o,
  output logic [REG_ADDR_W-1:0] fwd_rd_o,
  output logic [XLEN-1:0]       fwd_data_o,
  output wb_state_t             dbg_state
);

  localparam logic [WB_CNT_W-1:0] TIMEOUT_CNT = WB_CNT_W'(MEM_TIMEOUT);

  wb_state_t             state_q, state_d;
  logic [WB_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  load_size_t            ld_size_q, ld_size_d;
  logic                  ld_uns_q, ld_uns_d;
  logic [1:0]            ld_lsb_q, ld_lsb_d;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       ext_data;

  load_extend u_load_extend (
    .rdata       (mem_rdata_i),
    .size        (ld_size_q),
    .is_unsigned (ld_uns_q),
    .lsb         (ld_lsb_q),
    .result      (ext_data)
  );

  // Saturating increment so a very long stall can never wrap into a false
  // "fresh" count.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_lsb_d  = ld_lsb_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    err_d     = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (ex_valid_i) begin
          if (ex_is_load_i) begin
            state_d   = WB_WAIT_MEM;
            cnt_d     = '0;
            ld_rd_d   = ex_rd_i;
            ld_size_d = load_size_t'(ex_load_size_i);
            ld_uns_d  = ex_load_unsigned_i;
            ld_lsb_d  = ex_addr_lsb_i;
          end else if (ex_rd_i != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ex_rd_i;
            wr_data_d = ex_result_i;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid_i) begin
          state_d = WB_IDLE;
          if (mem_err_i) begin
            err_d = 1'b1;
          end else if (ld_rd_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ld_rd_q;
            wr_data_d = ext_data;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_CNT) begin
            state_d = WB_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_size_q <= LS_BYTE;
      ld_uns_q  <= 1'b0;
      ld_lsb_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_lsb_q  <= ld_lsb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign ex_ready_o      = (state_q == WB_IDLE);
  assign pend_valid_o    = (state_q == WB_WAIT_MEM);
  assign pend_rd_o       = pend_valid_o ? ld_rd_q : '0;
  assign rf_write_en_o   = wr_en_q;
  assign rf_write_addr_o = wr_addr_q;
  assign rf_write_data_o = wr_data_q;
  assign load_err_o      = err_q;
  assign dbg_state       = state_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid_o = wr_en_q;
  assign fwd_rd_o    = wr_addr_q;
  assign fwd_data_o  = wr_data_q;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_rd_o    = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (MEM_TIMEOUT=4): drivers push expected
// write/error events into exp_q, a negedge monitor pops and compares them.
module tb_writeback_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_load, ex_uns;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [1:0]  ex_size, ex_lsb;
  logic        mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        ex_ready, rf_we, pend_valid, load_err, fwd_valid;
  logic [4:0]  rf_addr, pend_rd, fwd_rd;
  logic [31:0] rf_data, fwd_data;
  wb_state_t   dbg_state;

  int checks = 0;
  int failures = 0;
  // Entry: {is_err, rd[4:0], data[31:0]}
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_unit #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_rd_i(ex_rd),
    .ex_result_i(ex_result), .ex_is_load_i(ex_is_load),
    .ex_load_size_i(ex_size), .ex_load_unsigned_i(ex_uns), .ex_addr_lsb_i(ex_lsb),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .rf_write_en_o(rf_we), .rf_write_addr_o(rf_addr), .rf_write_data_o(rf_data),
    .pend_valid_o(pend_valid), .pend_rd_o(pend_rd), .load_err_o(load_err),
    .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ex_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ex_ready) check("handshake_timeout", 32'(ex_ready), 32'd1);
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] res);
    if (rd != 5'd0) exp_q.push_back({1'b0, rd, res});
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = res;
    wait_ready();
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [1:0] lsb);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd; ex_size = size;
    ex_uns = uns; ex_lsb = lsb; ex_result = 32'hBAD0BAD0;
    wait_ready();
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    check("pend_valid_wait", 32'(pend_valid), 32'd1);
    check("pend_rd_wait", 32'(pend_rd), 32'(rd));
    check("ready_low_wait", 32'(ex_ready), 32'd0);
  endtask

  task automatic mem_resp(input logic [31:0] data, input logic err);
    mem_rvalid = 1'b1; mem_rdata = data; mem_err = err;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
  endtask

  // Monitor: every write or error pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [37:0] e;
    if (rf_we || load_err) begin
      check("we_err_exclusive", 32'(rf_we & load_err), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event we=%0b err=%0b addr=%0d data=%h expected=none",
                 rf_we, load_err, rf_addr, rf_data);
      end else begin
        e = exp_q.pop_front();
        check("event_is_err", 32'(load_err), 32'(e[37]));
        if (!e[37]) begin
          check("wr_addr", 32'(rf_addr), 32'(e[36:32]));
          check("wr_data", rf_data, e[31:0]);
        end
`ifdef WB_FORWARD_EN
        check("fwd_valid", 32'(fwd_valid), 32'(rf_we));
        check("fwd_data", fwd_data, rf_data);
`else
        check("fwd_valid_tied", 32'(fwd_valid), 32'd0);
        check("fwd_data_tied", fwd_data, 32'd0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [4:0]  lt_rd   [8] = '{5'd7, 5'd3, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
  logic [1:0]  lt_size [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
  logic        lt_uns  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0]  lt_lsb  [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [31:0] lt_rdat [8] = '{32'h1234F678, 32'h1234F678, 32'h1234F678, 32'h1234F678,
                               32'h1234F678, 32'h87654321, 32'h0000007F, 32'hCAFEF00D};
  logic [31:0] lt_exp  [8] = '{32'hFFFFFFF6, 32'h00001234, 32'h00000012, 32'hFFFFF678,
                               32'h1234F678, 32'h87654321, 32'h0000007F, 32'h00000000};

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_uns = 1'b0;
    ex_rd = '0; ex_result = '0; ex_size = '0; ex_lsb = '0;
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_pend", 32'(pend_valid), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(WB_IDLE));
    rst_n = 1'b1;
    tick();

    // Back-to-back ALU retires, including rd=0 which must not write.
    do_alu(5'd5, 32'hDEADBEEF);
    do_alu(5'd1, 32'h00000001);
    do_alu(5'd0, 32'h12345678);
    do_alu(5'd31, 32'h80000000);
    tick();

    for (int i = 0; i < 8; i++) begin
      if (lt_rd[i] != 5'd0) exp_q.push_back({1'b0, lt_rd[i], lt_exp[i]});
      do_load(lt_rd[i], lt_size[i], lt_uns[i], lt_lsb[i]);
      mem_resp(lt_rdat[i], 1'b0);
      check("ready_after_load", 32'(ex_ready), 32'd1);
    end

    // Slow response plus an ALU instruction stalled behind the load.
    exp_q.push_back({1'b0, 5'd20, 32'h00000020});
    exp_q.push_back({1'b0, 5'd21, 32'hA5A5A5A5});
    do_load(5'd20, 2'd2, 1'b0, 2'd0);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd21; ex_result = 32'hA5A5A5A5;
    tick();
    check("stall_ready_low", 32'(ex_ready), 32'd0);
    tick();
    mem_resp(32'h00000020, 1'b0);
    tick();
    ex_valid = 1'b0;
    tick();

    // Memory error: pulse, no write, ready again.
    exp_q.push_back({1'b1, 5'd0, 32'd0});
    do_load(5'd8, 2'd2, 1'b0, 2'd0);
    mem_resp(32'hFFFFFFFF, 1'b1);
    check("ready_after_err", 32'(ex_ready), 32'd1);
    tick();

    // Timeout after 4 WAIT_MEM cycles; late response must be ignored.
    exp_q.push_back({1'b1, 5'd0, 32'd0});
    do_load(5'd9, 2'd2, 1'b0, 2'd0);
    repeat (3) tick();
    check("timeout_still_wait", 32'(ex_ready), 32'd0);
    tick();
    check("timeout_idle", 32'(ex_ready), 32'd1);
    check("timeout_pend_clear", 32'(pend_valid), 32'd0);
    mem_resp(32'h55555555, 1'b0);
    tick();

    // Reset in the middle of a load abandons it silently.
    do_load(5'd15, 2'd2, 1'b0, 2'd0);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_state", 32'(dbg_state), 32'(WB_IDLE));
    check("midrst_pend", 32'(pend_valid), 32'd0);
    check("midrst_pend_rd", 32'(pend_rd), 32'd0);
    check("midrst_we", 32'(rf_we), 32'd0);
    check("midrst_addr", 32'(rf_addr), 32'd0);
    check("midrst_data", rf_data, 32'd0);
    check("midrst_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    mem_resp(32'h77777777, 1'b0);
    repeat (3) tick();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
